// File: rtl/bus_arb4.sv
// bus_arb4: four-requester round-robin arbiter for a shared resource.
//
// Handshake: a requester raises req[i] and keeps it high until it sees its
// bit in gnt. While a grant is active (busy=1), gnt/sel are frozen. The
// resource pulses ack for one cycle to end the grant. If no ack arrives
// within TIMEOUT grant cycles, the grant is withdrawn and err pulses for one
// cycle. Every release is followed by at least one idle cycle with gnt=0.
module bus_arb4 #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       ack,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       err
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t        state;
   logic [1:0]    last;
   logic [CW-1:0] cnt;

   logic [1:0]    pick_idx;
   logic          pick_vld;
   logic [1:0]    cand;

   // Round-robin search: first set req bit starting just after the last owner.
   always_comb begin
      pick_idx = last;
      pick_vld = 1'b0;
      cand     = last;
      for (int i = 1; i <= 4; i++) begin
         cand = last + 2'(i);
         if (!pick_vld && req[cand]) begin
            pick_idx = cand;
            pick_vld = 1'b1;
         end
      end
   end

   // Arbiter FSM with registered grant, select, busy and timeout error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= 4'b0000;
         sel   <= 2'd0;
         busy  <= 1'b0;
         err   <= 1'b0;
         cnt   <= '0;
         last  <= 2'd3;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  state <= GRANT;
                  gnt   <= 4'b0001 << pick_idx;
                  sel   <= pick_idx;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            GRANT: begin
               if (ack) begin
                  // ack wins even when it lands on the timeout cycle
                  state <= IDLE;
                  gnt   <= 4'b0000;
                  busy  <= 1'b0;
                  last  <= sel;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE;
                  gnt   <= 4'b0000;
                  busy  <= 1'b0;
                  last  <= sel;
                  err   <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= 4'b0000;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arb4.sv
// tb_bus_arb4: directed scoreboard bench for bus_arb4 (TIMEOUT=16).
// Each step drives inputs for one rising edge and queues the outputs
// expected after that edge; a negedge monitor pops and compares.
module tb_bus_arb4;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       ack;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       err;

   // expected vector layout: {gnt[3:0], sel[1:0], busy, err}
   logic [7:0] exp_q[$];
   string      name_q[$];

   int vectors;
   int miscompares;

   bus_arb4 #(.TIMEOUT(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .ack  (ack),
      .gnt  (gnt),
      .sel  (sel),
      .busy (busy),
      .err  (err)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // driver: apply inputs across one rising edge, then queue the expectation
   task automatic step(input string nm, input logic r, input logic [3:0] rq,
                       input logic a, input logic [3:0] eg, input logic [1:0] es,
                       input logic eb, input logic ee);
      rst = r;
      req = rq;
      ack = a;
      @(posedge clk);
      #1;
      exp_q.push_back({eg, es, eb, ee});
      name_q.push_back(nm);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [7:0] e;
         string      nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         vectors++;
         if ({gnt, sel, busy, err} !== e) begin
            miscompares++;
            $display("FAIL %s (vec %0d): got gnt=%b sel=%0d busy=%b err=%b, expected gnt=%b sel=%0d busy=%b err=%b",
                     nm, vectors, gnt, sel, busy, err, e[7:4], e[3:2], e[1], e[0]);
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      req = 4'b0000;
      ack = 1'b0;
      @(posedge clk);
      #1;

      // reset with everything asserted
      step("reset_0", 1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
      step("reset_1", 1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);

      // single requester, first edge after reset; ack three cycles later
      step("single_gnt",   0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      step("single_hold1", 0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      step("single_hold2", 0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      step("single_rel",   0, 4'b0100, 1, 4'b0000, 2'd2, 0, 0);
      // ack in idle ignored, sel holds last owner
      step("idle_ack",     0, 4'b0000, 1, 4'b0000, 2'd2, 0, 0);
      step("idle_quiet",   0, 4'b0000, 0, 4'b0000, 2'd2, 0, 0);

      // fairness from fresh reset: 0,1,2,3,0 with an idle gap each time
      step("fair_reset",   1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         logic [1:0] k;
         k = 2'(i % 4);
         step("fair_gnt", 0, 4'b1111, 0, 4'b0001 << k, k, 1, 0);
         step("fair_rel", 0, 4'b1111, 1, 4'b0000,      k, 0, 0);
      end

      // timeout: requester 1 held 16 cycles, then err for one cycle
      step("to_gnt", 0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
      for (int i = 1; i < 16; i++)
         step("to_hold", 0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
      step("to_rel_err", 0, 4'b0110, 0, 4'b0000, 2'd1, 0, 1);
      step("to_next",    0, 4'b0110, 0, 4'b0100, 2'd2, 1, 0);

      // coincidence: req dropped mid-grant, ack on the 16th grant cycle
      for (int i = 1; i < 16; i++)
         step("co_hold", 0, 4'b0000, 0, 4'b0100, 2'd2, 1, 0);
      step("co_rel_noerr", 0, 4'b0000, 1, 4'b0000, 2'd2, 0, 0);
      step("co_after",     0, 4'b0000, 0, 4'b0000, 2'd2, 0, 0);

      // mid-grant reset during a grant to 2
      step("mr_gnt",     0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      step("mr_hold",    0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      step("mr_reset",   1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
      step("mr_first",   0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
      step("mr_rel",     0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
      step("mr_next",    0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0);

      // reset on what would be the timeout edge: no err pulse
      for (int i = 1; i < 16; i++)
         step("rt_hold", 0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
      step("rt_reset", 1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      step("rt_after", 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

      req = 4'b0000;
      ack = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
